vga_plot_sink: RTL and testbench



---
 rtl/vga_plot_sink.sv | 154 +++++++++++++++
 tb/tb_vga_plot_sink.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_sink.sv
// rtl/vga_plot_sink.sv - pixel-plot sink: frame memory, plot/oob counters, raster dump over valid/ready
`timescale 1ns/1ps
module vga_plot_sink #(
    parameter int H_PIX = 160,
    parameter int V_PIX = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        start_dump,
    output logic [7:0]  dump_x,
    output logic [6:0]  dump_y,
    output logic [2:0]  dump_colour,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic        dump_done,
    output logic        busy,
    output logic [15:0] plot_count,
    output logic [15:0] oob_count
);
    localparam int            DEPTH  = H_PIX * V_PIX;
    localparam logic [7:0]    X_LIM  = 8'(H_PIX);
    localparam logic [6:0]    Y_LIM  = 7'(V_PIX);
    localparam logic [7:0]    X_LAST = 8'(H_PIX - 1);
    localparam logic [6:0]    Y_LAST = 7'(V_PIX - 1);
    localparam logic [14:0]   H_W    = 15'(H_PIX);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cur_x_q, cur_x_d;
    logic [6:0]  cur_y_q, cur_y_d;
    logic [2:0]  rdata_q;
    logic [15:0] plot_cnt_q, plot_cnt_d;
    logic [15:0] oob_cnt_q, oob_cnt_d;
    logic [2:0]  mem [DEPTH];

    logic        in_range;
    logic        wr_en;
    logic        rd_en;
    logic [14:0] wr_addr;
    logic [14:0] rd_addr;

    assign in_range = (vga_x < X_LIM) && (vga_y < Y_LIM);
    assign wr_en    = vga_plot && in_range;
    // The plot port owns the RAM: a fetch only goes out in a cycle with no plot.
    assign rd_en    = (state_q == FETCH) && !vga_plot;
    assign wr_addr  = 15'(vga_y) * H_W + 15'(vga_x);
    assign rd_addr  = 15'(cur_y_q) * H_W + 15'(cur_x_q);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= vga_colour;
        end
    end

    // Read register only loads in FETCH, so the presented colour is a snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            plot_cnt_q <= '0;
            oob_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            plot_cnt_q <= plot_cnt_d;
            oob_cnt_q  <= oob_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        case (state_q)
            IDLE: begin
                if (start_dump) begin
                    cur_x_d = '0;
                    cur_y_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!vga_plot) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (dump_ready) begin
                    if (cur_x_q == X_LAST && cur_y_q == Y_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                        if (cur_x_q == X_LAST) begin
                            cur_x_d = '0;
                            cur_y_d = cur_y_q + 7'd1;
                        end else begin
                            cur_x_d = cur_x_q + 8'd1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        dump_valid = (state_q == PRESENT);
        dump_done  = (state_q == DONE);
        busy       = (state_q != IDLE);
    end

    always_comb begin
        plot_cnt_d = plot_cnt_q;
        oob_cnt_d  = oob_cnt_q;
        if (vga_plot) begin
            if (in_range) begin
                if (plot_cnt_q != 16'hFFFF) begin
                    plot_cnt_d = plot_cnt_q + 16'd1;
                end
            end else begin
                if (oob_cnt_q != 16'hFFFF) begin
                    oob_cnt_d = oob_cnt_q + 16'd1;
                end
            end
        end
    end

    assign dump_x      = cur_x_q;
    assign dump_y      = cur_y_q;
    assign dump_colour = rdata_q;
    assign plot_count  = plot_cnt_q;
    assign oob_count   = oob_cnt_q;

endmodule

// File: tb/tb_vga_plot_sink.sv
// tb/tb_vga_plot_sink.sv - scoreboard bench for vga_plot_sink
`timescale 1ns/1ps
module tb_vga_plot_sink;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  vga_x = '0;
    logic [6:0]  vga_y = '0;
    logic [2:0]  vga_colour = '0;
    logic        vga_plot = 1'b0;
    logic        start_dump = 1'b0;
    logic [7:0]  dump_x;
    logic [6:0]  dump_y;
    logic [2:0]  dump_colour;
    logic        dump_valid;
    logic        dump_ready = 1'b1;
    logic        dump_done;
    logic        busy;
    logic [15:0] plot_count;
    logic [15:0] oob_count;

    always #5 clk = ~clk;

    vga_plot_sink #(.H_PIX(160), .V_PIX(120)) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .start_dump(start_dump),
        .dump_x(dump_x), .dump_y(dump_y), .dump_colour(dump_colour),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_done(dump_done),
        .busy(busy), .plot_count(plot_count), .oob_count(oob_count)
    );

    int          total = 0;
    int          bad = 0;
    int          accepts = 0;
    int          done_seen = 0;
    int          exp_plot = 0;
    logic [17:0] sb[$];
    logic [17:0] mon_e;
    logic [2:0]  exp_mem [19200];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] ent(input int i);
        return {7'(i / 160), 8'(i % 160), exp_mem[i]};
    endfunction

    task automatic do_plot(input int x, input int y, input logic [2:0] col);
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = col;
        vga_plot   = 1'b1;
        if (x < 160 && y < 120) begin
            exp_mem[y * 160 + x] = col;
            exp_plot++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented pixel must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dump_done) done_seen++;
            if (dump_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: pixel (%0d,%0d) presented, none expected", dump_x, dump_y);
                end else begin
                    mon_e = sb[0];
                    chk("dump_x", dump_x, mon_e[10:3]);
                    chk("dump_y", dump_y, mon_e[17:11]);
                    chk("dump_colour", dump_colour, mon_e[2:0]);
                    if (dump_ready) begin
                        mon_e = sb.pop_front();
                        accepts++;
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, dump_valid, 0);
        chk({tag, "_done"}, dump_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_x"}, dump_x, 0);
        chk({tag, "_y"}, dump_y, 0);
        chk({tag, "_colour"}, dump_colour, 0);
        chk({tag, "_plot_count"}, plot_count, 0);
        chk({tag, "_oob_count"}, oob_count, 0);
    endtask

    task automatic partial_dump_reset(input int n, input string tag);
        int base;
        base = accepts;
        for (int i = 0; i <= n; i++) sb.push_back(ent(i));
        dump_ready = 1'b1;
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        for (int c = 0; c < 200 && (accepts - base) < n; c++) tick();
        dump_ready = 1'b0;
        chk({tag, "_accepts"}, accepts - base, n);
        repeat (3) tick();
        chk({tag, "_held_valid"}, dump_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs({tag, "_rst"});
        sb.delete();
        exp_plot = 0;
        @(negedge clk);
        rst_n = 1'b1;
        dump_ready = 1'b1;
        tick();
    endtask

    initial begin
        int  done_iter;
        int  hold;
        int  stalls;
        int  idx;
        bit  done_flag;

        done_iter = -1;
        hold = 0;
        stalls = 0;
        done_flag = 0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill the frame with 3'b010 in raster order.
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                do_plot(x, y, 3'b010);
                tick();
            end
        end
        vga_plot = 1'b0;
        chk("fill_plot_count", plot_count, 19200);
        chk("fill_oob_count", oob_count, 0);

        do_plot(160, 0, 3'b111);   tick();
        do_plot(0, 120, 3'b111);   tick();
        do_plot(255, 127, 3'b111); tick();
        vga_plot = 1'b0;
        chk("oob_count", oob_count, 3);
        chk("oob_plot_count", plot_count, 19200);

        // Full dump: expected snapshot is the filled frame.
        for (int i = 0; i < 19200; i++) sb.push_back(ent(i));
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        chk("lat_busy", busy, 1);
        chk("lat_fetch_valid", dump_valid, 0);
        tick();
        chk("lat_valid", dump_valid, 1);
        chk("first_x", dump_x, 0);
        chk("first_y", dump_y, 0);

        // Overwrite each pixel with 3'b111 while it is presented; hold (3,0); stall the (10,0) fetch.
        for (int c = 0; c < 45000 && !done_flag; c++) begin
            vga_plot = 1'b0;
            dump_ready = 1'b1;
            if (dump_done) begin
                done_flag = 1;
                done_iter = c;
            end else begin
                if (dump_valid) begin
                    if (dump_x == 8'd3 && dump_y == 7'd0 && hold < 5) begin
                        dump_ready = 1'b0;
                        hold++;
                    end
                    do_plot(dump_x, dump_y, 3'b111);
                end else if (dump_x == 8'd10 && dump_y == 7'd0 && stalls < 3) begin
                    do_plot(0, 0, 3'b111);
                    stalls++;
                end
                tick();
            end
        end
        vga_plot = 1'b0;
        chk("dump_done_reached", done_flag, 1);
        chk("dump_cycles", done_iter, 38407);
        chk("done_busy", busy, 1);
        tick();
        chk("after_done_busy", busy, 0);
        chk("after_done_valid", dump_valid, 0);
        chk("sb_drained", sb.size(), 0);
        chk("done_pulses", done_seen, 1);
        chk("dump_plot_count", plot_count, 38408);
        chk("dump_oob_count", oob_count, 3);

        // Saturation: keep plotting 3'b111 in raster order up to 65540 accepted plots.
        idx = 0;
        while (exp_plot < 65540) begin
            do_plot(idx % 160, idx / 160, 3'b111);
            idx = (idx + 1) % 19200;
            tick();
            if (exp_plot == 65534) chk("pre_sat_count", plot_count, 65534);
        end
        vga_plot = 1'b0;
        chk("sat_plot_count", plot_count, 65535);
        chk("sat_oob_count", oob_count, 3);

        // Next dump shows the new colour; reset aborts it, and a new dump restarts at (0,0).
        partial_dump_reset(12, "abortA");
        partial_dump_reset(2, "abortB");
        chk("final_done_pulses", done_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
